// File: rtl/uart_param_core.sv
// rtl/uart_param_core.sv - parametrised full-duplex UART core with TX/RX FIFOs
// Frame format and baud divisor are fixed at elaboration; both FIFOs are first-word-fall-through.

module uart_param_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

module uart_param_core #(
  parameter int P_CLK_HZ     = 50_000_000,
  parameter int P_BAUD       = 115200,
  parameter int P_DATA_BITS  = 8,
  parameter int P_PARITY     = 0,
  parameter int P_STOP_BITS  = 1,
  parameter int P_FIFO_DEPTH = 16
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   uart_rx,
  output logic                   uart_tx,
  input  logic [P_DATA_BITS-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   tx_busy,
  output logic [P_DATA_BITS-1:0] rx_data,
  output logic                   rx_frame_err,
  output logic                   rx_parity_err,
  output logic                   rx_valid,
  input  logic                   rx_ready,
  output logic                   rx_overrun
);
  localparam int              DB        = P_DATA_BITS;
  localparam int              DIV       = (P_CLK_HZ + P_BAUD / 2) / P_BAUD;
  localparam int              CW        = $clog2(DIV);
  localparam logic [CW-1:0]   BIT_END   = CW'(DIV - 1);
  localparam logic [CW-1:0]   HALF_END  = CW'(DIV / 2 - 1);
  localparam logic [3:0]      LAST_DATA = 4'(DB - 1);
  localparam logic [3:0]      LAST_STOP = 4'(P_STOP_BITS - 1);
  localparam bit              PAR_EN    = (P_PARITY != 0);

  function automatic logic par_of(input logic [DB-1:0] d);
    return (P_PARITY == 1) ? ~^d : ^d;
  endfunction

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_PUSH, RX_BREAK} rx_state_t;

  // ---------------- TX path ----------------
  logic          tx_full, tx_empty, tx_pop;
  logic [DB-1:0] tx_head;
  tx_state_t     tx_state, tx_state_nx;
  logic [CW-1:0] tx_cnt, tx_cnt_nx;
  logic [3:0]    tx_bit, tx_bit_nx;
  logic [DB-1:0] tx_shift, tx_shift_nx;
  logic          tx_par, tx_par_nx;
  logic          tx_line, tx_q, tx_busy_d, tx_tick;

  uart_param_fifo #(.W(DB), .DEPTH(P_FIFO_DEPTH)) u_tx_fifo (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .wr_en  (tx_valid && !tx_full),
    .wr_data(tx_data),
    .rd_en  (tx_pop),
    .rd_data(tx_head),
    .full   (tx_full),
    .empty  (tx_empty)
  );

  assign tx_tick = (tx_cnt == BIT_END);

  always_comb begin
    tx_state_nx = tx_state;
    tx_cnt_nx   = tx_cnt + 1'b1;
    tx_bit_nx   = tx_bit;
    tx_shift_nx = tx_shift;
    tx_par_nx   = tx_par;
    tx_pop      = 1'b0;
    tx_line     = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_nx = '0;
        if (!tx_empty) begin
          tx_pop      = 1'b1;
          tx_shift_nx = tx_head;
          tx_par_nx   = par_of(tx_head);
          tx_state_nx = TX_START;
        end
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_tick) begin
          tx_cnt_nx   = '0;
          tx_bit_nx   = '0;
          tx_state_nx = TX_DATA;
        end
      end
      TX_DATA: begin
        tx_line = tx_shift[0];
        if (tx_tick) begin
          tx_cnt_nx   = '0;
          tx_shift_nx = tx_shift >> 1;
          if (tx_bit == LAST_DATA) begin
            tx_bit_nx   = '0;
            tx_state_nx = PAR_EN ? TX_PARITY : TX_STOP;
          end else begin
            tx_bit_nx = tx_bit + 1'b1;
          end
        end
      end
      TX_PARITY: begin
        tx_line = tx_par;
        if (tx_tick) begin
          tx_cnt_nx   = '0;
          tx_bit_nx   = '0;
          tx_state_nx = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          tx_cnt_nx = '0;
          if (tx_bit == LAST_STOP) begin
            tx_bit_nx = '0;
            // Chain straight into the next start bit so bursts have no idle gap.
            if (!tx_empty) begin
              tx_pop      = 1'b1;
              tx_shift_nx = tx_head;
              tx_par_nx   = par_of(tx_head);
              tx_state_nx = TX_START;
            end else begin
              tx_state_nx = TX_IDLE;
            end
          end else begin
            tx_bit_nx = tx_bit + 1'b1;
          end
        end
      end
      default: tx_state_nx = TX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      tx_par    <= 1'b0;
      tx_q      <= 1'b1;
      tx_busy_d <= 1'b0;
    end else begin
      tx_state  <= tx_state_nx;
      tx_cnt    <= tx_cnt_nx;
      tx_bit    <= tx_bit_nx;
      tx_shift  <= tx_shift_nx;
      tx_par    <= tx_par_nx;
      tx_q      <= tx_line;
      tx_busy_d <= (tx_state != TX_IDLE);
    end
  end

  // The line is registered one cycle behind the FSM; tx_busy_d covers that trailing cycle.
  assign uart_tx  = tx_q;
  assign tx_ready = !tx_full;
  assign tx_busy  = !tx_empty || (tx_state != TX_IDLE) || tx_busy_d;

  // ---------------- RX path ----------------
  logic            rx_s1, rx_s2, rx_s3, rx_fall, rx_tick;
  rx_state_t       rx_state, rx_state_nx;
  logic [CW-1:0]   rx_cnt, rx_cnt_nx;
  logic [3:0]      rx_bit, rx_bit_nx;
  logic [DB-1:0]   rx_shift, rx_shift_nx;
  logic            rx_par_s, rx_par_s_nx;
  logic            rx_ferr, rx_ferr_nx;
  logic            rx_perr, rx_push_req, rx_wr, rx_pop, rx_full, rx_empty;
  logic [DB+1:0]   rx_head;

  // Synchroniser resets low so a line already low at release is not taken as a falling edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_s1 <= 1'b0;
      rx_s2 <= 1'b0;
      rx_s3 <= 1'b0;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall = rx_s3 && !rx_s2;
  assign rx_tick = (rx_cnt == BIT_END);

  always_comb begin
    rx_state_nx = rx_state;
    rx_cnt_nx   = rx_cnt + 1'b1;
    rx_bit_nx   = rx_bit;
    rx_shift_nx = rx_shift;
    rx_par_s_nx = rx_par_s;
    rx_ferr_nx  = rx_ferr;
    rx_push_req = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_nx = '0;
        if (rx_fall) rx_state_nx = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_END) begin
          rx_cnt_nx   = '0;
          rx_bit_nx   = '0;
          rx_state_nx = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_cnt_nx   = '0;
          rx_shift_nx = {rx_s2, rx_shift[DB-1:1]};
          if (rx_bit == LAST_DATA) begin
            rx_bit_nx   = '0;
            rx_state_nx = PAR_EN ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_nx = rx_bit + 1'b1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_tick) begin
          rx_cnt_nx   = '0;
          rx_par_s_nx = rx_s2;
          rx_state_nx = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          rx_cnt_nx   = '0;
          rx_ferr_nx  = !rx_s2;
          rx_state_nx = RX_PUSH;
        end
      end
      RX_PUSH: begin
        rx_cnt_nx   = '0;
        rx_push_req = 1'b1;
        rx_state_nx = rx_ferr ? RX_BREAK : RX_IDLE;
      end
      RX_BREAK: begin
        rx_cnt_nx = '0;
        if (rx_s2) rx_state_nx = RX_IDLE;
      end
      default: rx_state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_par_s <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_state <= rx_state_nx;
      rx_cnt   <= rx_cnt_nx;
      rx_bit   <= rx_bit_nx;
      rx_shift <= rx_shift_nx;
      rx_par_s <= rx_par_s_nx;
      rx_ferr  <= rx_ferr_nx;
    end
  end

  assign rx_perr = PAR_EN && (rx_par_s != par_of(rx_shift));

  // A same-cycle pop frees the slot being written, so a full FIFO can still accept.
  assign rx_pop     = !rx_empty && rx_ready;
  assign rx_wr      = rx_push_req && (!rx_full || rx_pop);
  assign rx_overrun = rx_push_req && rx_full && !rx_pop;

  uart_param_fifo #(.W(DB + 2), .DEPTH(P_FIFO_DEPTH)) u_rx_fifo (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .wr_en  (rx_wr),
    .wr_data({rx_ferr, rx_perr, rx_shift}),
    .rd_en  (rx_pop),
    .rd_data(rx_head),
    .full   (rx_full),
    .empty  (rx_empty)
  );

  assign rx_valid = !rx_empty;
  assign {rx_frame_err, rx_parity_err, rx_data} = rx_valid ? rx_head : '0;
endmodule

// File: tb/tb_uart_param_core.sv
// tb/tb_uart_param_core.sv - self-checking bench for uart_param_core
// 8E2 frames at an 8-cycle bit period, 4-deep FIFOs.

module tb_uart_param_core;
  localparam int CLK_HZ = 800;
  localparam int BAUD   = 100;
  localparam int DIV    = 8;
  localparam int DB     = 8;
  localparam int PAR    = 2;
  localparam int STOPB  = 2;
  localparam int DEPTH  = 4;
  localparam int FLEN   = (1 + DB + 1 + STOPB) * DIV;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_line, loop_en;
  logic          uart_rx, uart_tx;
  logic [DB-1:0] tx_data;
  logic          tx_valid, tx_ready, tx_busy;
  logic [DB-1:0] rx_data;
  logic          rx_frame_err, rx_parity_err, rx_valid, rx_ready, rx_overrun;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            ovr_cnt = 0;
  logic [DB+1:0] rxq[$];
  bit            frame_bits[$];
  logic [DB-1:0] tx_words[8];
  logic [DB-1:0] rx_words[5];

  assign uart_rx = loop_en ? uart_tx : rx_line;
  always #5 clk = ~clk;

  uart_param_core #(
    .P_CLK_HZ(CLK_HZ), .P_BAUD(BAUD), .P_DATA_BITS(DB),
    .P_PARITY(PAR), .P_STOP_BITS(STOPB), .P_FIFO_DEPTH(DEPTH)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun)
  );

  // Scoreboard: capture every word the consumer pops, count overrun pulses.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && rx_valid && rx_ready) rxq.push_back({rx_frame_err, rx_parity_err, rx_data});
    if (rx_overrun) ovr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit even_par(input logic [DB-1:0] d);
    int ones = 0;
    for (int i = 0; i < DB; i++) ones += int'(d[i]);
    return (ones % 2) != 0;
  endfunction

  function automatic void build_frame(input logic [DB-1:0] d, input bit flip, input bit stop0);
    frame_bits.push_back(1'b0);
    for (int i = 0; i < DB; i++) frame_bits.push_back(d[i]);
    frame_bits.push_back(even_par(d) ^ flip);
    for (int s = 0; s < STOPB; s++) frame_bits.push_back(!stop0);
  endfunction

  task automatic expect_rx(input string tag, input logic [DB+1:0] exp);
    logic [DB+1:0] got;
    got = 'x;
    if (rxq.size() != 0) got = rxq.pop_front();
    check(tag, got, exp);
  endtask

  // Push n words with tx_valid held; compare line and tx_busy cycle by cycle to the frame model.
  task automatic tx_run(input int n);
    int idx = 0, total, bad_line = 0, bad_busy = 0;
    frame_bits.delete();
    for (int i = 0; i < n; i++) build_frame(tx_words[i], 1'b0, 1'b0);
    total    = frame_bits.size() * DIV;
    tx_data  = tx_words[0];
    tx_valid = 1'b1;
    for (int c = 0; c < total + 6; c++) begin
      bit acc, exp_line, exp_busy;
      acc = tx_valid && tx_ready;
      @(negedge clk);
      if (acc) begin
        idx++;
        if (idx < n) tx_data = tx_words[idx];
        else tx_valid = 1'b0;
      end
      exp_line = (c >= 2 && c < 2 + total) ? frame_bits[(c - 2) / DIV] : 1'b1;
      exp_busy = (c < 2 + total);
      if (uart_tx !== exp_line) bad_line++;
      if (tx_busy !== exp_busy) bad_busy++;
    end
    check("tx_line_bad_cycles", bad_line, 0);
    check("tx_busy_bad_cycles", bad_busy, 0);
    check("tx_words_accepted", idx, n);
  endtask

  task automatic rx_send(input logic [DB-1:0] d, input bit flip, input bit stop0);
    frame_bits.delete();
    build_frame(d, flip, stop0);
    foreach (frame_bits[i]) begin
      rx_line = frame_bits[i];
      repeat (DIV) @(negedge clk);
    end
    rx_line = 1'b1;
  endtask

  initial begin
    logic [DB-1:0] d;
    rst_n = 1'b0; rx_line = 1'b1; loop_en = 1'b0;
    tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_flags", {rx_frame_err, rx_parity_err, rx_overrun}, 0);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("idle_no_rx_word", rxq.size(), 0);
    check("idle_rx_valid", rx_valid, 0);

    // Single 0x41 frame in loopback
    loop_en = 1'b1;
    tx_words[0] = 8'h41;
    tx_run(1);
    repeat (4) @(negedge clk);
    expect_rx("loop_0x41", {2'b00, 8'h41});

    // Burst of 6 random words, more than the TX FIFO holds
    for (int i = 0; i < 6; i++) tx_words[i] = DB'($urandom);
    tx_run(6);
    repeat (4) @(negedge clk);
    check("burst_rx_count", rxq.size(), 6);
    for (int i = 0; i < 6; i++) expect_rx($sformatf("burst_word%0d", i), {2'b00, tx_words[i]});

    // Directly driven RX frames
    loop_en = 1'b0;
    d = DB'($urandom);
    rx_send(d, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    expect_rx("rx_parity_flip", {2'b01, d});
    for (int i = 0; i < 3; i++) begin
      d = DB'($urandom);
      rx_send(d, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      expect_rx($sformatf("rx_frame%0d", i), {2'b00, d});
    end

    // Short low glitch must not produce a word
    rx_line = 1'b0;
    repeat (2) @(negedge clk);
    rx_line = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    check("glitch_no_word", rxq.size(), 0);

    // Break: one bad-stop frame followed by 3 frames of continuous low
    rx_line = 1'b0;
    repeat (4 * FLEN) @(negedge clk);
    rx_line = 1'b1;
    repeat (DIV) @(negedge clk);
    check("break_word_count", rxq.size(), 1);
    expect_rx("break_word", {2'b10, {DB{1'b0}}});
    d = DB'($urandom);
    rx_send(d, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    expect_rx("after_break", {2'b00, d});

    // Overrun: fill the RX FIFO with consumer stalled
    rx_ready = 1'b0;
    ovr_cnt  = 0;
    for (int i = 0; i < 5; i++) begin
      rx_words[i] = DB'($urandom);
      rx_send(rx_words[i], 1'b0, 1'b0);
    end
    repeat (4) @(negedge clk);
    check("overrun_pulses", ovr_cnt, 1);
    check("full_rx_valid", rx_valid, 1);
    check("full_head_data", rx_data, rx_words[0]);
    rx_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("drain_count", rxq.size(), 4);
    for (int i = 0; i < 4; i++) expect_rx($sformatf("drain_word%0d", i), {2'b00, rx_words[i]});
    check("drain_rx_valid", rx_valid, 0);

    // Asynchronous reset in the middle of a start bit
    tx_data  = DB'($urandom);
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("midframe_start_bit", uart_tx, 0);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_uart_tx", uart_tx, 1);
    check("async_rst_tx_busy", tx_busy, 0);
    check("async_rst_tx_ready", tx_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * FLEN) @(negedge clk);
    check("post_rst_tx_idle", {tx_busy, uart_tx}, 2'b01);
    check("post_rst_no_rx", rxq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
